// File: rtl/w21_pkg.sv
// rtl/w21_pkg.sv - shared state type, latency and address-width helpers for the W21 output-layer sequencer
package w21_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, RESULT, DONE} w21_state_t;

  localparam int unsigned DEF_MUL_LAT = 3;
  localparam int unsigned LAT = DEF_MUL_LAT + 1;

  // Address-to-product latency: one ROM cycle in front of the multiplier pipeline.
  function automatic int unsigned lat_of(input int unsigned mul_lat);
    return mul_lat + 1;
  endfunction

  function automatic int unsigned addr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/w21_vld_delay.sv
// rtl/w21_vld_delay.sv - reset-clearable shift register aligning {first,valid} with the multiplier output
module w21_vld_delay #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic first,
  input  logic valid,
  output logic first_q,
  output logic valid_q
);

  logic [DEPTH-1:0] first_sr;
  logic [DEPTH-1:0] valid_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      first_sr <= '0;
      valid_sr <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        first_sr[i] <= first_sr[i-1];
        valid_sr[i] <= valid_sr[i-1];
      end
      first_sr[0] <= first;
      valid_sr[0] <= valid;
    end
  end

  assign first_q = first_sr[DEPTH-1];
  assign valid_q = valid_sr[DEPTH-1];

endmodule

// File: rtl/w21_output_layer_ctrl.sv
// rtl/w21_output_layer_ctrl.sv - W21 output-layer MAC sequencer with per-class valid/ready results
// Optional argmax of class scores is enabled by defining W21CTL_ARGMAX_EN.
module w21_output_layer_ctrl
  import w21_pkg::*;
#(
  parameter int unsigned N_HIDDEN = 20,
  parameter int unsigned N_CLASS  = 10,
  parameter int unsigned MUL_LAT  = DEF_MUL_LAT,
  parameter int unsigned ACC_W    = 24
) (
  input  logic                                      clk,
  input  logic                                      W21ctl_rst,
  input  logic                                      start,
  output logic                                      busy,
  output logic [addr_w(N_HIDDEN)-1:0]               h_addr,
  output logic [addr_w(N_HIDDEN*N_CLASS)-1:0]       w_addr,
  output logic                                      addr_vld,
  output logic                                      acc_load,
  output logic                                      acc_en,
  output logic [addr_w(N_CLASS)-1:0]                class_idx,
  input  logic signed [ACC_W-1:0]                   acc_in,
  output logic                                      res_valid,
  input  logic                                      res_ready,
  output logic                                      done,
  output logic [addr_w(N_CLASS)-1:0]                pred_digit
);

  localparam int unsigned LAT_C = lat_of(MUL_LAT);
  localparam int unsigned HW = addr_w(N_HIDDEN);
  localparam int unsigned CW = addr_w(N_CLASS);
  localparam int unsigned DW = addr_w(LAT_C);
  localparam logic [HW-1:0] H_LAST = HW'(N_HIDDEN - 1);
  localparam logic [CW-1:0] C_LAST = CW'(N_CLASS - 1);
  localparam logic [DW-1:0] D_LAST = DW'(LAT_C - 1);

  w21_state_t    state;
  logic [DW-1:0] drain_cnt;
  logic          hs;
  logic          first_q;
  logic          valid_q;

  assign hs = res_valid & res_ready;

  always_ff @(posedge clk) begin
    if (W21ctl_rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      h_addr    <= '0;
      w_addr    <= '0;
      addr_vld  <= 1'b0;
      class_idx <= '0;
      res_valid <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= ISSUE;
          busy      <= 1'b1;
          addr_vld  <= 1'b1;
          h_addr    <= '0;
          w_addr    <= '0;
          class_idx <= '0;
        end
        ISSUE: if (h_addr == H_LAST) begin
          state     <= DRAIN;
          addr_vld  <= 1'b0;
          drain_cnt <= '0;
        end else begin
          h_addr <= h_addr + 1'b1;
          w_addr <= w_addr + 1'b1;
        end
        // Wait until the last product of the class has been accumulated.
        DRAIN: if (drain_cnt == D_LAST) begin
          state     <= RESULT;
          res_valid <= 1'b1;
        end else begin
          drain_cnt <= drain_cnt + 1'b1;
        end
        RESULT: if (hs) begin
          res_valid <= 1'b0;
          if (class_idx == C_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= ISSUE;
            class_idx <= class_idx + 1'b1;
            h_addr    <= '0;
            w_addr    <= w_addr + 1'b1;
            addr_vld  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  w21_vld_delay #(.DEPTH(LAT_C)) u_vld_delay (
    .clk     (clk),
    .rst     (W21ctl_rst),
    .first   (addr_vld & (h_addr == '0)),
    .valid   (addr_vld),
    .first_q (first_q),
    .valid_q (valid_q)
  );

  assign acc_load = first_q;
  assign acc_en   = valid_q & ~first_q;

`ifdef W21CTL_ARGMAX_EN
  logic signed [ACC_W-1:0] best;
  logic [CW-1:0]           best_idx;
  logic                    take;

  // Strictly-greater update keeps the lower index on ties.
  assign take = (class_idx == '0) || (acc_in > best);

  always_ff @(posedge clk) begin
    if (W21ctl_rst) begin
      best       <= '0;
      best_idx   <= '0;
      pred_digit <= '0;
    end else if (state == RESULT && hs) begin
      if (take) begin
        best     <= acc_in;
        best_idx <= class_idx;
      end
      if (class_idx == C_LAST) pred_digit <= take ? class_idx : best_idx;
    end
  end
`else
  logic unused_acc;
  assign unused_acc = ^acc_in;
  assign pred_digit = '0;
`endif

endmodule
